linear_interpolator: RTL and testbench
======================================

Name: linear_interpolator

Overview:
- Strobe-driven upsampler, the counterpart to the moving-average decimator. The averager reduces a sample stream; this block expands one.
- Each accepted 8-bit input sample produces 2^INTERP_POWER output samples, one per clock. The outputs are linearly interpolated from the previous input sample toward the new one.
- Uses the standard tile pinout (ui_in / uo_out / uio_*), so it can drive a DAC-side path or feed the averager in loopback tests.

Parameters:
- INTERP_POWER, 2, log2 of the upsampling ratio N = 2^INTERP_POWER. Legal range 1..4.
- DATA_W, 8, sample width. Fixed by the pinout; declared in the package.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ui_in  in  8  input sample x_in (unsigned)
- uio_in  in  8  bit0 = in_strobe (one-cycle pulse, sample valid on ui_in); bits 7:1 ignored
- uo_out  out  8  interpolated output sample y (unsigned)
- uio_out  out  8  bit1 = out_valid, bit2 = ready, bit3 = overrun (sticky); bits 0 and 7:4 = 0
- uio_oe  out  8  constant 8'b0000_1110

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; x_prev = 0; acc = 0; step counter k = 0.
  - uo_out = 0, out_valid = 0, overrun = 0, ready = 1.
- States: IDLE (no sample yet), HOLD (primed, waiting), INTERP (emitting).
- Accept rule: a sample is accepted when in_strobe = 1 and ready = 1.
  - ready = 1 in IDLE and HOLD, and in INTERP only when k = N-1 (the last step).
- IDLE + accept:
  - x_prev <= x_in; go to HOLD.
  - No output is produced; the first sample only primes the block.
- HOLD or INTERP(last step) + accept:
  - delta <= x_in - x_prev, signed, DATA_W+1 bits.
  - acc <= x_prev << INTERP_POWER, signed, DATA_W+INTERP_POWER+2 bits.
  - x_prev <= x_in; k <= 0; enter (or stay in) INTERP.
- INTERP, each cycle:
  - uo_out <= acc >>> INTERP_POWER (arithmetic shift, floor), low DATA_W bits.
  - out_valid <= 1; acc <= acc + delta; k <= k+1.
  - Output k therefore equals floor((x_prev_old·N + k·delta)/N).
  - Results always lie between the two endpoints, so no saturation logic is needed.
- Latency: the accept edge is at cycle t; out_valid is high for cycles t+1 .. t+N, carrying outputs k = 0..N-1.
  - A strobe accepted on the last step makes the next burst continue seamlessly: out_valid has no gap.
- INTERP at k = N-1 with no accept: return to HOLD. out_valid drops the following cycle.
- When out_valid = 0, uo_out holds its last value.
- Strobe while ready = 0 (mid-burst):
  - The sample is dropped; overrun <= 1, sticky until reset.
  - The burst in progress is unaffected.
- Reset mid-INTERP: everything returns to reset values. The next strobe primes again, with no output.
- Width rules: delta is in [-255, +255]; acc is sized so that acc + N·delta never overflows.

Decomposition:
- Package interp_pkg:
  - DATA_W = 8.
  - State encoding localparams: IDLE = 2'b00, HOLD = 2'b01, INTERP = 2'b11.
  - uio bit-index constants: STROBE_BIT = 0, VALID_BIT = 1, READY_BIT = 2, OVR_BIT = 3.
  - UIO_OE_MASK = 8'h0E.
- One sub-module is natural: interp_step_acc. It holds the acc/delta/k datapath, with inputs load, x_prev, x_new, step and outputs y, last.
- The top level holds the FSM, the handshake and the overrun flag.

Test Plan (INTERP_POWER = 2):
- Priming and ramp up:
  - Reset, then strobe 0x10 -> out_valid stays 0, ready = 1.
  - Strobe 0x20 -> next 4 cycles uo_out = 0x10, 0x14, 0x18, 0x1C with out_valid = 1, then out_valid = 0 and uo_out holds 0x1C.
- Ramp down and floor rounding:
  - From x_prev 0x20, strobe 0x10 -> 0x20, 0x1C, 0x18, 0x14.
  - From 0x00, strobe 0x03 -> 0x00, 0x00, 0x01, 0x02.
  - From 0x03, strobe 0x00 -> 0x03, 0x02, 0x01, 0x00.
- Full-scale:
  - From 0x00, strobe 0xFF -> 0x00, 0x3F, 0x7F, 0xBF.
  - Then strobe on the last step with 0x00 -> continuous out_valid; next burst 0xFF, 0xBF, 0x7F, 0x3F.
- Overrun:
  - Strobe 0x80 on the 2nd cycle of a burst -> burst completes unchanged, sample dropped, uio_out[3] = 1 and stays 1.
  - uio_oe reads 0x0E throughout.
- Reset mid-burst:
  - Assert rst_n = 0 during step 2 -> uo_out = 0, out_valid = 0, overrun = 0 immediately (async).
  - After release, strobe 0x40 -> no output (re-prime).
  - Strobe 0x44 -> 0x40, 0x41, 0x42, 0x43.

Source files
------------

// File: rtl/linear_interpolator_pkg.sv
// Shared definitions for the linear interpolator (upsampler).
// Contents: sample width, FSM state encoding, uio bit positions and
// the constant uio output-enable mask of the tile pinout.
package interp_pkg;

   localparam int DATA_W = 8;

   // IDLE: nothing received yet, HOLD: primed and waiting,
   // INTERP: emitting a burst of interpolated samples.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      HOLD   = 2'b01,
      INTERP = 2'b11
   } state_e;

   localparam int STROBE_BIT = 0;
   localparam int VALID_BIT  = 1;
   localparam int READY_BIT  = 2;
   localparam int OVR_BIT    = 3;

   localparam logic [DATA_W-1:0] UIO_OE_MASK = 8'h0E;

endpackage

// File: rtl/linear_interpolator_if.sv
// Tile pinout bundle for the linear interpolator.
//   ui_in   : input sample
//   uio_in  : bit STROBE_BIT = in_strobe
//   uo_out  : interpolated output sample
//   uio_out : out_valid / ready / overrun flags
//   uio_oe  : bidirectional pin output enables
// master = stimulus side, slave = the interpolator.
interface linear_interpolator_if;
   import interp_pkg::*;

   logic [DATA_W-1:0] ui_in;
   logic [DATA_W-1:0] uio_in;
   logic [DATA_W-1:0] uo_out;
   logic [DATA_W-1:0] uio_out;
   logic [DATA_W-1:0] uio_oe;

   modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/linear_interpolator_step_acc.sv
// Interpolation datapath: step accumulator, signed delta and step counter.
//   load   : start a new burst from x_prev toward x_new
//   step   : advance one interpolation step (ignored when load is high)
//   x_prev : previous (start) sample
//   x_new  : new (end) sample
//   y      : floor(acc / N), the current interpolated sample
//   last   : step counter is at N-1
module interp_step_acc
   import interp_pkg::*;
#(
   parameter int INTERP_POWER = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [DATA_W-1:0] x_prev,
   input  logic [DATA_W-1:0] x_new,
   output logic [DATA_W-1:0] y,
   output logic              last
);

   // Two guard bits above x*N keep acc + N*delta from overflowing.
   localparam int ACC_W = DATA_W + INTERP_POWER + 2;

   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [DATA_W:0]         delta_q, delta_d;
   logic [INTERP_POWER-1:0] k_q, k_d;

   always_comb begin
      acc_d   = acc_q;
      delta_d = delta_q;
      k_d     = k_q;
      if (load) begin
         // 9-bit two's-complement difference of the zero-extended samples.
         delta_d = {1'b0, x_new} - {1'b0, x_prev};
         acc_d   = '0;
         acc_d[DATA_W+INTERP_POWER-1:INTERP_POWER] = x_prev;
         k_d     = '0;
      end else if (step) begin
         acc_d = acc_q + {{(ACC_W-DATA_W-1){delta_q[DATA_W]}}, delta_q};
         k_d   = k_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         delta_q <= '0;
         k_q     <= '0;
      end else begin
         acc_q   <= acc_d;
         delta_q <= delta_d;
         k_q     <= k_d;
      end
   end

   // acc stays within [0, 255*N], so the arithmetic shift reduces to a slice.
   assign y    = acc_q[DATA_W+INTERP_POWER-1:INTERP_POWER];
   assign last = &k_q;

endmodule

// File: rtl/linear_interpolator.sv
// Strobe-driven linear-interpolating upsampler (ratio N = 2^INTERP_POWER).
// Each accepted sample after the first produces N outputs ramping from the
// previous sample toward the new one, one per clock.
//   clk, rst_n : clock, async active-low reset
//   bus        : tile pinout (slave side), see linear_interpolator_if
module linear_interpolator
   import interp_pkg::*;
#(
   parameter int INTERP_POWER = 2
) (
   input  logic clk,
   input  logic rst_n,
   linear_interpolator_if.slave bus
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] x_prev_q, x_prev_d;
   logic [DATA_W-1:0] uo_q, uo_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;

   logic              strobe, ready, accept, load, last;
   logic [DATA_W-1:0] y;
   logic              unused_uio;

   assign strobe     = bus.uio_in[STROBE_BIT];
   assign unused_uio = ^bus.uio_in[DATA_W-1:1];

   interp_step_acc #(.INTERP_POWER(INTERP_POWER)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (state_q == INTERP),
      .x_prev (x_prev_q),
      .x_new  (bus.ui_in),
      .y      (y),
      .last   (last)
   );

   always_comb begin
      // Mid-burst the block only takes a sample on the final step, which
      // lets back-to-back bursts run without a gap in out_valid.
      ready  = (state_q != INTERP) || last;
      accept = strobe && ready;
      // The very first sample only primes x_prev.
      load   = accept && (state_q != IDLE);

      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = HOLD;
         HOLD:    if (accept) state_d = INTERP;
         INTERP:  if (last && !accept) state_d = HOLD;
         default: state_d = IDLE;
      endcase

      x_prev_d = accept ? bus.ui_in : x_prev_q;
      valid_d  = (state_q == INTERP);
      uo_d     = (state_q == INTERP) ? y : uo_q;
      ovr_d    = ovr_q || (strobe && !ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_prev_q <= '0;
         uo_q     <= '0;
         valid_q  <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_prev_q <= x_prev_d;
         uo_q     <= uo_d;
         valid_q  <= valid_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      bus.uio_out            = '0;
      bus.uio_out[VALID_BIT] = valid_q;
      bus.uio_out[READY_BIT] = ready;
      bus.uio_out[OVR_BIT]   = ovr_q;
   end

   assign bus.uo_out = uo_q;
   assign bus.uio_oe = UIO_OE_MASK;

endmodule

// File: tb/tb_linear_interpolator.sv
// Self-checking bench for linear_interpolator (INTERP_POWER = 2).
// Reference model: pending-output queue filled with the closed-form
// interpolation values floor((a*N + k*(b-a))/N) when a sample is accepted.
module tb_linear_interpolator;

   localparam int P = 2;
   localparam int N = 1 << P;

   logic clk = 1'b0;
   logic rst_n;

   linear_interpolator_if bus ();

   linear_interpolator #(.INTERP_POWER(P)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit      m_primed;
   int      m_xp;
   int      m_uo;
   bit      m_valid;
   bit      m_ovr;
   int      m_pend[$];

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_primed = 0;
      m_xp     = 0;
      m_uo     = 0;
      m_valid  = 0;
      m_ovr    = 0;
      m_pend.delete();
   endfunction

   function automatic bit model_ready();
      return m_pend.size() <= 1;
   endfunction

   function automatic void model_edge(input bit s, input int x);
      bit rdy;
      rdy = model_ready();
      if (m_pend.size() > 0) begin
         m_uo    = m_pend.pop_front();
         m_valid = 1;
      end else begin
         m_valid = 0;
      end
      if (s && rdy) begin
         if (m_primed) begin
            for (int k = 0; k < N; k++)
               m_pend.push_back((m_xp * N + k * (x - m_xp)) / N);
         end
         m_primed = 1;
         m_xp     = x;
      end else if (s) begin
         m_ovr = 1;
      end
   endfunction

   task automatic check_outputs();
      chk("uo_out",    int'(bus.uo_out),     m_uo);
      chk("out_valid", int'(bus.uio_out[1]), int'(m_valid));
      chk("ready",     int'(bus.uio_out[2]), int'(model_ready()));
      chk("overrun",   int'(bus.uio_out[3]), int'(m_ovr));
      chk("uio_zero",  int'(bus.uio_out & 8'hF1), 0);
      chk("uio_oe",    int'(bus.uio_oe),     'h0E);
   endtask

   // one clock: check at negedge, drive, then advance the model at posedge
   task automatic drive(input bit s, input int x);
      @(negedge clk);
      check_outputs();
      bus.ui_in  = 8'(x);
      bus.uio_in = {7'($urandom), s};
      @(posedge clk);
      model_edge(s, x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255));
   endtask

   // asynchronous reset between edges; outputs must clear without a clock
   task automatic reset_mid();
      @(negedge clk);
      check_outputs();
      bus.uio_in = 8'h00;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_uo",    int'(bus.uo_out),     0);
      chk("rst_valid", int'(bus.uio_out[1]), 0);
      chk("rst_ovr",   int'(bus.uio_out[3]), 0);
      chk("rst_ready", int'(bus.uio_out[2]), 1);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      model_edge(1'b0, 0);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      model_reset();
      #12;
      chk("reset_uo",    int'(bus.uo_out),     0);
      chk("reset_valid", int'(bus.uio_out[1]), 0);
      chk("reset_ready", int'(bus.uio_out[2]), 1);
      chk("reset_ovr",   int'(bus.uio_out[3]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);

      // priming and ramp up
      drive(1'b1, 'h10); idle(3);
      drive(1'b1, 'h20); idle(6);
      chk("ramp_hold", int'(bus.uo_out), 'h1C);
      // ramp down, floor rounding
      drive(1'b1, 'h10); idle(6);
      drive(1'b1, 'h00); idle(6);
      drive(1'b1, 'h03); idle(6);
      drive(1'b1, 'h00); idle(6);
      // full scale, then seamless back-to-back burst
      drive(1'b1, 'hFF); idle(3);
      drive(1'b1, 'h00); idle(6);
      // overrun: strobe on the 2nd burst cycle
      drive(1'b1, 'h40);
      drive(1'b1, 'h80); idle(6);
      chk("ovr_sticky", int'(bus.uio_out[3]), 1);
      // reset during step 2, then re-prime
      drive(1'b1, 'h20); idle(2);
      reset_mid();
      drive(1'b1, 'h40); idle(3);
      drive(1'b1, 'h44); idle(6);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) reset_mid();
         else drive($urandom_range(0, 99) < 35, $urandom_range(0, 255));
      end
      idle(6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
